// File: rtl/corelet_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : corelet_ctrl
// Brief   : Sequencer for one weight-load / activation-execute / drain pass
//           of a corelet.
//           Optional macro CORELET_CTRL_RELU_EN drives inst[34] from the relu
//           value captured at start.
// Revision: 1.0 - initial release
// ============================================================================
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [len_bw-1:0]  len,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    input  logic               relu,
    input  logic               ofifo_o_valid,
    output logic [34:0]        inst,
    output logic               mem_rd,
    output logic [addr_bw-1:0] mem_addr,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_FETCH, S_W_LOAD, S_W_FLUSH, S_X_FETCH, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    localparam int c_flush = row + col;
    localparam int c_cw    = (len_bw + 1 > $clog2(c_flush + 2)) ? len_bw + 1 : $clog2(c_flush + 2);
    localparam logic [c_cw-1:0] c_one      = c_cw'(1);
    localparam logic [c_cw-1:0] c_col      = c_cw'(col);
    localparam logic [c_cw-1:0] c_col_m1   = c_cw'(col - 1);
    localparam logic [c_cw-1:0] c_flush_m1 = c_cw'(c_flush - 1);

    state_t              r_state, w_nxt_state;
    logic [c_cw-1:0]     r_cnt, w_nxt_cnt, w_drain_cnt, w_len_ext;
    logic [len_bw-1:0]   r_len;
    logic [addr_bw-1:0]  r_w_base, r_x_base, w_w_base_sel, w_addr_nxt;
    logic                r_load, r_exec, r_l0_wr, r_l0_rd, r_relu;
    logic                w_rd_nxt, w_ofifo_rd;

    assign w_len_ext   = {{(c_cw - len_bw){1'b0}}, r_len};
    assign w_drain_cnt = r_cnt + {{(c_cw - 1){1'b0}}, ofifo_o_valid};

    // In DRAIN the counter counts accepted OFIFO words rather than cycles.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + c_one;
        case (r_state)
            S_IDLE: begin
                w_nxt_cnt = '0;
                if (start) w_nxt_state = S_W_FETCH;
            end
            S_W_FETCH: if (r_cnt == c_col) begin
                w_nxt_state = S_W_LOAD;
                w_nxt_cnt   = '0;
            end
            S_W_LOAD: if (r_cnt == c_col_m1) begin
                w_nxt_state = S_W_FLUSH;
                w_nxt_cnt   = '0;
            end
            S_W_FLUSH: if (r_cnt == c_flush_m1) begin
                w_nxt_state = (r_len == '0) ? S_DRAIN : S_X_FETCH;
                w_nxt_cnt   = '0;
            end
            S_X_FETCH: if (r_cnt == w_len_ext) begin
                w_nxt_state = S_EXEC;
                w_nxt_cnt   = '0;
            end
            S_EXEC: if (r_cnt == w_len_ext - c_one) begin
                w_nxt_state = S_DRAIN;
                w_nxt_cnt   = '0;
            end
            S_DRAIN: begin
                w_nxt_cnt = w_drain_cnt;
                if (w_drain_cnt >= w_len_ext) begin
                    w_nxt_state = S_DONE;
                    w_nxt_cnt   = '0;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with it.
    assign w_w_base_sel = (r_state == S_IDLE) ? w_base : r_w_base;
    assign w_rd_nxt     = ((w_nxt_state == S_W_FETCH) && (w_nxt_cnt < c_col)) ||
                          ((w_nxt_state == S_X_FETCH) && (w_nxt_cnt < w_len_ext));
    assign w_addr_nxt   = ((w_nxt_state == S_W_FETCH) ? w_w_base_sel : r_x_base) +
                          addr_bw'(w_nxt_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_len    <= '0;
            r_w_base <= '0;
            r_x_base <= '0;
            r_load   <= 1'b0;
            r_exec   <= 1'b0;
            r_l0_wr  <= 1'b0;
            r_l0_rd  <= 1'b0;
            r_relu   <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            if (r_state == S_IDLE && start) begin
                r_len    <= len;
                r_w_base <= w_base;
                r_x_base <= x_base;
            end
            r_load  <= (w_nxt_state == S_W_LOAD);
            r_exec  <= (w_nxt_state == S_EXEC);
            r_l0_rd <= (w_nxt_state == S_W_LOAD) || (w_nxt_state == S_EXEC);
            r_l0_wr <= ((w_nxt_state == S_W_FETCH) || (w_nxt_state == S_X_FETCH)) &&
                       (w_nxt_cnt != '0);
            mem_rd  <= w_rd_nxt;
            if (w_rd_nxt) mem_addr <= w_addr_nxt;
            busy    <= (w_nxt_state != S_IDLE);
            done    <= (w_nxt_state == S_DONE);
`ifdef CORELET_CTRL_RELU_EN
            r_relu  <= (w_nxt_state != S_IDLE) && ((r_state == S_IDLE) ? relu : r_relu);
`else
            r_relu  <= 1'b0;
`endif
        end
    end

`ifndef CORELET_CTRL_RELU_EN
    logic w_unused_relu;
    assign w_unused_relu = relu;
`endif

    // OFIFO read strobe passes straight through so a word is popped the cycle it appears.
    assign w_ofifo_rd = (r_state == S_DRAIN) && ofifo_o_valid;
    assign inst = {r_relu, w_ofifo_rd, 26'b0, w_ofifo_rd, 2'b00, r_l0_rd, r_l0_wr, r_exec, r_load};

endmodule
`default_nettype wire

// File: tb/tb_corelet_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_corelet_ctrl
// Brief   : Scoreboard bench for corelet_ctrl against a phase-level pass model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_corelet_ctrl;
    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int ABW = 11;
    localparam int LBW = 8;

    logic           clk = 1'b0;
    logic           reset, start, relu, ofifo_o_valid;
    logic [LBW-1:0] len;
    logic [ABW-1:0] w_base, x_base;
    logic [34:0]    inst;
    logic           mem_rd;
    logic [ABW-1:0] mem_addr;
    logic           busy, done;

    always #5 clk = ~clk;

    corelet_ctrl #(.row(ROW), .col(COL), .addr_bw(ABW), .len_bw(LBW)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .w_base(w_base),
        .x_base(x_base), .relu(relu), .ofifo_o_valid(ofifo_o_valid),
        .inst(inst), .mem_rd(mem_rd), .mem_addr(mem_addr), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [34:0]    inst;
        logic           rd;
        logic [ABW-1:0] addr;
        logic           busy;
        logic           done;
    } exp_t;

    exp_t           sbq[$];
    int             errors = 0;
    int             checks = 0;
    logic [ABW-1:0] m_last_addr;
    logic           m_relu;
    bit             m_pend_rst, m_aborted;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: one expected record per clock cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("inst",     64'(inst),     64'(e.inst));
            chk("mem_rd",   64'(mem_rd),   64'(e.rd));
            chk("mem_addr", 64'(mem_addr), 64'(e.addr));
            chk("busy",     64'(busy),     64'(e.busy));
            chk("done",     64'(done),     64'(e.done));
        end
    end

    function automatic bit rbit();
        return $urandom_range(0, 1) == 1;
    endfunction

    function automatic exp_t idle_e();
        exp_t e;
        e      = '0;
        e.addr = m_last_addr;
        return e;
    endfunction

    task automatic step(input logic s, input logic r, input logic v, input exp_t e);
        start         = s;
        reset         = r;
        ofifo_o_valid = v;
        if (!s) begin
            len    = LBW'($urandom);
            w_base = ABW'($urandom);
            x_base = ABW'($urandom);
            relu   = rbit();
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic emit(input bit ld, input bit ex, input bit wr, input bit rd,
                        input bit rdm, input logic [ABW-1:0] adr,
                        input bit v, input bit ofr, input bit dn);
        exp_t e;
        if (m_aborted) return;
        e          = '0;
        e.inst[0]  = ld;
        e.inst[1]  = ex;
        e.inst[2]  = wr;
        e.inst[3]  = rd;
        e.inst[6]  = ofr;
        e.inst[33] = ofr;
        e.inst[34] = m_relu;
        if (rdm) m_last_addr = adr;
        e.rd   = rdm;
        e.addr = m_last_addr;
        e.busy = 1'b1;
        e.done = dn;
        if (m_pend_rst) begin
            step(rbit(), 1'b1, v, e);
            m_pend_rst = 1'b0;
            m_aborted  = 1'b1;
        end else begin
            step($urandom_range(0, 3) == 0, 1'b0, v, e);
        end
    endtask

    function automatic bit pick(input int vmode, input int j);
        bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        if (vmode == 0) return 1'b1;
        if (vmode == 1) return (j < 7) ? pat[j] : 1'b1;
        return (j > 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
    endfunction

    // One pass in phase terms: weight fetch, load, flush, activation fetch, execute, drain, done.
    task automatic run_pass(input int L, input logic [ABW-1:0] wb, input logic [ABW-1:0] xb,
                            input bit rl, input int gap, input int vmode, input int rst_exec);
        int   cnt;
        int   j;
        bit   v;
        exp_t z;
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, rbit(), idle_e());
        len    = LBW'(L);
        w_base = wb;
        x_base = xb;
        relu   = rl;
        step(1'b1, 1'b0, rbit(), idle_e());
`ifdef CORELET_CTRL_RELU_EN
        m_relu = rl;
`else
        m_relu = 1'b0;
`endif
        m_aborted = 1'b0;
        for (int k = 0; k <= COL; k++)
            emit(0, 0, k >= 1, 0, k < COL, wb + ABW'(k), rbit(), 0, 0);
        for (int k = 0; k < COL; k++)
            emit(1, 0, 0, 1, 0, '0, rbit(), 0, 0);
        for (int k = 0; k < ROW + COL; k++)
            emit(0, 0, 0, 0, 0, '0, rbit(), 0, 0);
        if (L > 0) begin
            for (int k = 0; k <= L; k++)
                emit(0, 0, k >= 1, 0, k < L, xb + ABW'(k), rbit(), 0, 0);
            for (int k = 0; k < L; k++) begin
                if (k == rst_exec) m_pend_rst = 1'b1;
                emit(0, 1, 0, 1, 0, '0, rbit(), 0, 0);
            end
        end
        cnt = 0;
        j   = 0;
        do begin
            v = pick(vmode, j);
            emit(0, 0, 0, 0, 0, '0, v, v, 0);
            if (v) cnt++;
            j++;
        end while (cnt < L && !m_aborted);
        emit(0, 0, 0, 0, 0, '0, rbit(), 0, 1);
        if (m_aborted) begin
            m_last_addr = '0;
            z = '0;
            step(1'b1, 1'b1, rbit(), z);
            step(1'b0, 1'b0, rbit(), z);
        end
        m_relu = 1'b0;
    endtask

    initial begin
        exp_t z;
        z             = '0;
        reset         = 1'b1;
        start         = 1'b0;
        ofifo_o_valid = 1'b0;
        len           = '0;
        w_base        = '0;
        x_base        = '0;
        relu          = 1'b0;
        m_last_addr   = '0;
        m_relu        = 1'b0;
        m_pend_rst    = 1'b0;
        m_aborted     = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 1'b0, z);
        step(1'b0, 1'b0, 1'b1, z);

        run_pass(4,   11'h010, 11'h040, 1'b1, 0, 0, -1);
        run_pass(0,   11'h123, 11'h200, 1'b0, 2, 0, -1);
        run_pass(4,   11'h300, 11'h380, 1'b1, 1, 1, -1);
        run_pass(6,   11'h7FE, 11'h7FC, 1'b0, 0, 2, -1);
        run_pass(4,   11'h010, 11'h040, 1'b1, 1, 0, 2);
        run_pass(3,   11'h055, 11'h0AA, 1'b1, 0, 2, -1);
        for (int p = 0; p < 20; p++)
            run_pass($urandom_range(0, 12), ABW'($urandom), ABW'($urandom), rbit(),
                     $urandom_range(0, 3), 2, -1);
        run_pass(255, 11'h700, 11'h780, 1'b1, 1, 0, -1);
        step(1'b0, 1'b0, 1'b0, idle_e());

        @(negedge clk);
        #1;
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
